ad_ip_jesd204_tpl_adc_pn_sequencer: RTL

- Link-clock-domain controller inserted between the TPL ADC regmap and the ADC core on the `pn_seq_sel` path.
- On request, it steps all channels through a fixed list of PN patterns. For each pattern it waits a settle window, then monitors `pn_err`/`pn_oos` over a dwell window of valid beats.
- It records a sticky per-channel, per-pattern fail flag.
- When idle it passes the regmap's `pn_seq_sel` through unchanged, so normal register control is unaffected.

---
 rtl/ad_ip_jesd204_tpl_adc_pkg.sv | 20 ++
 rtl/ad_ip_jesd204_tpl_adc_pn_fail_acc.sv | 31 +++
 rtl/ad_ip_jesd204_tpl_adc_pn_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_pkg.sv
// Shared encodings and helpers for the TPL ADC PN-pattern sequencer.
package ad_ip_jesd204_tpl_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DWELL  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [3:0] PN_SEL_PN9  = 4'd0;
  localparam logic [3:0] PN_SEL_PN23 = 4'd1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pn_fail_acc.sv
// Sticky per-pattern fail flags for one channel; flag idx_i is set on an enabled error beat.
module ad_ip_jesd204_tpl_adc_pn_fail_acc #(
  parameter int NUM_PATTERNS = 2,
  parameter int IDX_W        = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic                    err_i,
  output logic [NUM_PATTERNS-1:0] fail_o
);

  logic [NUM_PATTERNS-1:0] fail_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fail_q <= '0;
    end else if (clr_i) begin
      fail_q <= '0;
    end else if (en_i && err_i) begin
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        if (idx_i == IDX_W'(p)) fail_q[p] <= 1'b1;
      end
    end
  end

  assign fail_o = fail_q;

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pn_sequencer.sv
// Steps all channels through PATTERN_LIST, settling then dwelling on each pattern,
// and records sticky per-channel/per-pattern PN fail flags. Passes cfg through when idle.
module ad_ip_jesd204_tpl_adc_pn_sequencer
  import ad_ip_jesd204_tpl_adc_pkg::*;
#(
  parameter int                      NUM_CHANNELS   = 1,
  parameter int                      NUM_PATTERNS   = 2,
  parameter logic [NUM_PATTERNS*4-1:0] PATTERN_LIST = {PN_SEL_PN23, PN_SEL_PN9},
  parameter int                      SETTLE_CYCLES  = 64,
  parameter int                      DWELL_CYCLES   = 1024,
  parameter int                      TIMEOUT_CYCLES = 65536
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_CHANNELS*4-1:0]          cfg_pn_seq_sel,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               link_valid,
  input  logic [NUM_CHANNELS-1:0]            pn_err,
  input  logic [NUM_CHANNELS-1:0]            pn_oos,
  output logic [NUM_CHANNELS*4-1:0]          pn_seq_sel,
  output logic                               busy,
  output logic                               done,
  output logic                               aborted,
  output logic                               timeout,
  output logic                               result_valid,
  output logic [NUM_CHANNELS*NUM_PATTERNS-1:0] fail
);

  localparam int IDX_W    = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam int BEAT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int BEAT_W   = cnt_width(BEAT_MAX);
  localparam int WD_W     = cnt_width(TIMEOUT_CYCLES);

  localparam logic [BEAT_W-1:0] SETTLE_LAST = BEAT_W'(SETTLE_CYCLES - 1);
  localparam logic [BEAT_W-1:0] DWELL_LAST  = BEAT_W'(DWELL_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_PATTERNS - 1);

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [WD_W-1:0]           wd_q;
  logic [NUM_CHANNELS*4-1:0] pn_q;
  logic                      busy_q, done_q, aborted_q, timeout_q, rv_q;
  logic [3:0]                pat_sel;
  logic                      acc_clr, acc_en;

  always_comb begin
    pat_sel = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      if (idx_q == IDX_W'(i)) pat_sel = PATTERN_LIST[i*4 +: 4];
    end
  end

  assign acc_clr = (state_q == ST_IDLE) && start && !abort;
  assign acc_en  = (state_q == ST_DWELL) && link_valid && !abort;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      beat_q    <= '0;
      wd_q      <= '0;
      pn_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      timeout_q <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pn_q <= cfg_pn_seq_sel;
          if (start && !abort) begin
            timeout_q <= 1'b0;
            rv_q      <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_APPLY;
          end
        end
        ST_DONE: begin
          pn_q    <= cfg_pn_seq_sel;
          state_q <= ST_IDLE;
        end
        default: begin
          if (abort) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else if ((state_q == ST_SETTLE || state_q == ST_DWELL) && wd_q == WD_LAST) begin
            timeout_q <= 1'b1;
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            case (state_q)
              ST_APPLY: begin
                pn_q    <= {NUM_CHANNELS{pat_sel}};
                beat_q  <= '0;
                wd_q    <= '0;
                state_q <= ST_SETTLE;
              end
              ST_SETTLE: begin
                wd_q <= wd_q + 1'b1;
                if (link_valid) begin
                  if (beat_q == SETTLE_LAST) begin
                    beat_q  <= '0;
                    state_q <= ST_DWELL;
                  end else begin
                    beat_q <= beat_q + 1'b1;
                  end
                end
              end
              ST_DWELL: begin
                wd_q <= wd_q + 1'b1;
                if (link_valid) begin
                  if (beat_q == DWELL_LAST) begin
                    beat_q  <= '0;
                    state_q <= ST_NEXT;
                  end else begin
                    beat_q <= beat_q + 1'b1;
                  end
                end
              end
              ST_NEXT: begin
                if (idx_q == IDX_LAST) begin
                  done_q  <= 1'b1;
                  rv_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
                end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= ST_APPLY;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // One accumulator per channel; flattened as fail[p*NUM_CHANNELS + c].
  logic [NUM_PATTERNS-1:0] acc_fail [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    ad_ip_jesd204_tpl_adc_pn_fail_acc #(
      .NUM_PATTERNS (NUM_PATTERNS),
      .IDX_W        (IDX_W)
    ) u_acc (
      .clk    (clk),
      .resetn (resetn),
      .clr_i  (acc_clr),
      .en_i   (acc_en),
      .idx_i  (idx_q),
      .err_i  (pn_err[c] | pn_oos[c]),
      .fail_o (acc_fail[c])
    );
    for (genvar p = 0; p < NUM_PATTERNS; p++) begin : g_pat
      assign fail[p*NUM_CHANNELS + c] = acc_fail[c][p];
    end
  end

  assign pn_seq_sel   = pn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign timeout      = timeout_q;
  assign result_valid = rv_q;

endmodule
